// File: rtl/step_sched.sv
// step_sched: tick scheduler for a single-stepped or free-running datapath.
//
// Produces a one-cycle clock enable (tick) for a downstream state register,
// either free-running every 2^TICK_DIV cycles while run is high, or once per
// press of the step button. x_raw/y_raw are synchronized (and optionally
// debounced), then captured into x_q/y_q on the edge that raises tick.
//
// Optional feature macro: STEP_SCHED_DEBOUNCE_EN
//   defined   : each synchronized input changes its filtered value only after
//               differing from it for 2^DB_W consecutive cycles
//   undefined : filtered value is the synchronizer output, DB_W unused
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   run        in   level, requests free-running ticks
//   step       in   asynchronous button, rising edge requests one tick
//   x_raw      in   asynchronous datapath input x
//   y_raw      in   asynchronous datapath input y
//   tick       out  one-cycle clock-enable pulse
//   x_q, y_q   out  x/y captured with tick
//   mode       out  00 IDLE, 01 RUN, 10 STEP
//   step_cnt   out  number of ticks issued (wraps)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting; run starts RUN, a step edge starts STEP
// RUN   | divider counts, tick every 2^TICK_DIV cycles; step ignored
// STEP  | single cycle with tick high, then IDLE or RUN

module step_sched #(
    parameter int TICK_DIV = 23,
    parameter int DB_W     = 16,
    parameter int CNT_W    = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             x_raw,
    input  logic             y_raw,
    output logic             tick,
    output logic             x_q,
    output logic             y_q,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] step_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_e;

    localparam logic [TICK_DIV-1:0] DIV_MAX = '1;

    // bit 0 = step, bit 1 = x, bit 2 = y
    logic [2:0] raw_in;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] filt;

    assign raw_in = {y_raw, x_raw, step};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef STEP_SCHED_DEBOUNCE_EN
    localparam logic [DB_W-1:0] DB_MAX = '1;
    // Settling time from reset release until a level present at the pins
    // reaches the filtered value.
    localparam int WARM_N = 2 + 2**DB_W;
    localparam int WARM_W = DB_W + 2;

    logic [2:0]      filt_q;
    logic [2:0]      filt_d;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            filt_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign filt = filt_q;
`else
    localparam int WARM_N = 2;
    localparam int WARM_W = 2;

    assign filt = sync2_q;
`endif

    // The synchronizer restarts from 0 after reset, so a button held through
    // reset would look like a fresh press once it propagates. The edge
    // register is held at 1 until the pipeline has settled.
    logic              edge_q;
    logic              edge_d;
    logic [WARM_W-1:0] warm_q;
    logic [WARM_W-1:0] warm_d;
    logic              step_req;

    always_comb begin
        warm_d = warm_q;
        edge_d = filt[0];
        if (warm_q != '0) begin
            warm_d = warm_q - WARM_W'(1);
            edge_d = 1'b1;
        end
    end

    assign step_req = filt[0] & ~edge_q;

    state_e             state_q;
    state_e             state_d;
    logic [TICK_DIV-1:0] div_q;
    logic [TICK_DIV-1:0] div_d;
    logic               run_tc;
    logic               tick_q;
    logic               tick_d;
    logic               x_d;
    logic               y_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: state_d = run ? ST_RUN : ST_IDLE;
            ST_RUN:  if (!run) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Terminal count only yields a tick if RUN continues; a falling run
        // in that cycle drops the tick.
        run_tc = (state_q == ST_RUN) && run && (div_q == DIV_MAX);

        // Counting only while staying in RUN also clears the divider on entry.
        div_d = '0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            div_d = div_q + TICK_DIV'(1);
        end

        tick_d = run_tc || (state_d == ST_STEP);
        x_d    = tick_d ? filt[1] : x_q;
        y_d    = tick_d ? filt[2] : y_q;
        cnt_d  = tick_d ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            edge_q  <= 1'b1;
            warm_q  <= WARM_W'(WARM_N);
            state_q <= ST_IDLE;
            div_q   <= '0;
            tick_q  <= 1'b0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            edge_q  <= edge_d;
            warm_q  <= warm_d;
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tick     = tick_q;
    assign mode     = state_q;
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_step_sched.sv
module tb_step_sched;

    localparam int TICK_DIV = 4;
    localparam int DB_W     = 2;
    localparam int CNT_W    = 4;
    localparam int PERIOD   = 1 << TICK_DIV;
    localparam int DBN      = 1 << DB_W;
    localparam int CNT_MOD  = 1 << CNT_W;
`ifdef STEP_SCHED_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
    localparam int WARM  = 2 + DBN;
`else
    localparam bit DB_ON = 1'b0;
    localparam int WARM  = 2;
`endif

    logic             CLOCK_50 = 1'b0;
    logic             reset    = 1'b1;
    logic             run      = 1'b0;
    logic             step     = 1'b0;
    logic             x_raw    = 1'b0;
    logic             y_raw    = 1'b0;
    logic             tick;
    logic             x_q;
    logic             y_q;
    logic [1:0]       mode;
    logic [CNT_W-1:0] step_cnt;

    step_sched #(
        .TICK_DIV(TICK_DIV),
        .DB_W    (DB_W),
        .CNT_W   (CNT_W)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .run     (run),
        .step    (step),
        .x_raw   (x_raw),
        .y_raw   (y_raw),
        .tick    (tick),
        .x_q     (x_q),
        .y_q     (y_q),
        .mode    (mode),
        .step_cnt(step_cnt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Inputs as seen after the synchronizer: the raw value two edges back,
    // with samples taken during reset counting as 0.
    bit       m_valid = 1'b0;
    int       e_mode = 0, e_tick = 0, e_x = 0, e_y = 0, e_cnt = 0;
    int       run_age = 0;
    int       since_rst = 0;
    bit       prev_fs = 1'b0;
    bit [2:0] mf = '0;
    int       mc [3];
    logic [2:0] hq [$];

    initial begin
        logic [2:0] fv;
        logic [2:0] f;
        bit         req;
        bit         rtick;
        int         nxt;
        hq.push_back(3'b000);
        hq.push_back(3'b000);
        for (int i = 0; i < 3; i++) mc[i] = 0;
        forever begin
            @(posedge CLOCK_50);
            fv = hq[0];
            if (reset) begin
                e_mode = 0; e_tick = 0; e_x = 0; e_y = 0; e_cnt = 0;
                run_age = 0; since_rst = 0; prev_fs = 1'b0; mf = '0;
                for (int i = 0; i < 3; i++) mc[i] = 0;
                m_valid = 1'b1;
            end else begin
                if (DB_ON) begin
                    f = mf;
                    for (int i = 0; i < 3; i++) begin
                        if (fv[i] != mf[i]) begin
                            mc[i]++;
                            if (mc[i] == DBN) begin
                                mf[i] = fv[i];
                                mc[i] = 0;
                            end
                        end else begin
                            mc[i] = 0;
                        end
                    end
                end else begin
                    f = fv;
                end
                since_rst++;
                // Presses are not recognised until a level present at reset
                // release has had time to reach the filtered value.
                req     = f[0] && !prev_fs && (since_rst > WARM + 1);
                prev_fs = f[0];
                rtick   = (e_mode == 1) && run && (((run_age + 1) % PERIOD) == 0);
                if (e_mode == 0) nxt = run ? 1 : (req ? 2 : 0);
                else             nxt = run ? 1 : 0;
                if (nxt == 1) run_age = (e_mode == 1) ? run_age + 1 : 0;
                e_tick = (rtick || (nxt == 2)) ? 1 : 0;
                if (e_tick == 1) begin
                    e_x   = int'(f[1]);
                    e_y   = int'(f[2]);
                    e_cnt = (e_cnt + 1) % CNT_MOD;
                end
                e_mode = nxt;
            end
            hq.push_back(reset ? 3'b000 : {y_raw, x_raw, step});
            void'(hq.pop_front());
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (m_valid) begin
                chk("mdl_mode", int'(mode), e_mode);
                chk("mdl_tick", int'(tick), e_tick);
                chk("mdl_x_q", int'(x_q), e_x);
                chk("mdl_y_q", int'(y_q), e_y);
                chk("mdl_step_cnt", int'(step_cnt), e_cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        wait_cyc(n);
        reset = 1'b0;
    endtask

    task automatic pulse_count(input int len, output int nt);
        nt   = 0;
        step = 1'b1;
        for (int i = 0; i < 30; i++) begin
            wait_cyc(1);
            if (tick) nt++;
            if (i == len - 1) step = 1'b0;
        end
    endtask

    initial begin
        int entry, nt, t1, t2, nstep, after, tx, ty, budget;
        bit was_step, done;

        // reset state
        do_reset(3);
        chk("rst_mode", int'(mode), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_x_q", int'(x_q), 0);
        chk("rst_y_q", int'(y_q), 0);
        chk("rst_cnt", int'(step_cnt), 0);
        wait_cyc(8);

        // run held 40 cycles: ticks 16 and 32 cycles after RUN entry
        run = 1'b1; entry = -1; nt = 0; t1 = -1; t2 = -1;
        for (int i = 1; i <= 40; i++) begin
            wait_cyc(1);
            if (mode == 2'b01 && entry < 0) entry = i;
            if (tick) begin
                nt++;
                if (nt == 1) t1 = i - entry;
                else if (nt == 2) t2 = i - entry;
            end
        end
        chk("run40_entry", entry, 1);
        chk("run40_ticks", nt, 2);
        chk("run40_first", t1, 16);
        chk("run40_second", t2, 32);
        chk("run40_cnt", int'(step_cnt), 2);
        run = 1'b0;
        wait_cyc(3);
        chk("run40_idle", int'(mode), 0);

        // single clean press with x=1, y=0
        do_reset(2);
        x_raw = 1'b1; y_raw = 1'b0;
        wait_cyc(10);
        step = 1'b1; nt = 0; nstep = 0; after = -1; tx = -1; ty = -1; was_step = 1'b0;
        for (int i = 0; i < 30; i++) begin
            wait_cyc(1);
            if (was_step && after < 0) after = int'(mode);
            was_step = (mode == 2'b10);
            if (was_step) nstep++;
            if (tick) begin
                nt++;
                tx = int'(x_q);
                ty = int'(y_q);
            end
            if (i == 5) step = 1'b0;
        end
        chk("press_ticks", nt, 1);
        chk("press_x_q", tx, 1);
        chk("press_y_q", ty, 0);
        chk("press_step_cycles", nstep, 1);
        chk("press_mode_after", after, 0);
        chk("press_cnt", int'(step_cnt), 1);

        // short glitch vs long press
        x_raw = 1'b0; y_raw = 1'b1;
        wait_cyc(5);
        pulse_count(3, nt);
        chk("glitch3_ticks", nt, DB_ON ? 0 : 1);
        pulse_count(8, nt);
        chk("press8_ticks", nt, 1);
        chk("press8_cnt", int'(step_cnt), DB_ON ? 2 : 3);

        // 17 free-running ticks: count 1..15, 0, 1
        do_reset(2);
        wait_cyc(WARM + 2);
        run = 1'b1; nt = 0; budget = 0;
        while (nt < 17 && budget < 400) begin
            wait_cyc(1);
            budget++;
            if (tick) begin
                chk("wrap_cnt", int'(step_cnt), (nt + 1) % 16);
                nt++;
            end
        end
        chk("wrap_ticks", nt, 17);
        chk("wrap_final", int'(step_cnt), 1);
        run = 1'b0;
        wait_cyc(3);

        // run falls in the terminal-count cycle: no tick
        run = 1'b1; entry = -1; nt = 0;
        for (int i = 1; i <= 25; i++) begin
            wait_cyc(1);
            if (mode == 2'b01 && entry < 0) entry = i;
            if (tick) nt++;
            if (entry >= 0 && i - entry == 15) run = 1'b0;
        end
        chk("tcfall_ticks", nt, 0);
        chk("tcfall_mode", int'(mode), 0);
        chk("tcfall_cnt", int'(step_cnt), 1);

        // button held through reset release
        step = 1'b1;
        do_reset(3);
        nt = 0;
        for (int i = 0; i < 20; i++) begin
            wait_cyc(1);
            if (tick) nt++;
        end
        chk("held_ticks", nt, 0);
        chk("held_mode", int'(mode), 0);
        step = 1'b0;
        wait_cyc(10);

        // reset mid-RUN at divider = 10 (after the first tick)
        run = 1'b1; entry = -1; done = 1'b0; budget = 0;
        while (!done && budget < 60) begin
            wait_cyc(1);
            budget++;
            if (mode == 2'b01 && entry < 0) entry = budget;
            if (entry >= 0 && budget - entry == 26) begin
                chk("midrun_precnt", int'(step_cnt), 1);
                reset = 1'b1;
                done  = 1'b1;
            end
        end
        chk("midrun_reached", int'(done), 1);
        wait_cyc(1);
        reset = 1'b0;
        chk("midrun_mode", int'(mode), 0);
        chk("midrun_tick", int'(tick), 0);
        chk("midrun_cnt", int'(step_cnt), 0);
        wait_cyc(1);
        chk("midrun_tick_after", int'(tick), 0);
        run = 1'b0;
        wait_cyc(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/step_sched.md
STEP_SCHED -- requirements
Module: step_sched

Interface
REQ-001 SHALL have parameter TICK_DIV, default 23, meaning the RUN tick period is 2^TICK_DIV clock cycles.
REQ-002 SHALL have parameter DB_W, default 16, meaning the debounce stable time is 2^DB_W cycles.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the step counter width.
REQ-004 SHALL have port CLOCK_50  input  1  system clock; one clock, all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port run  input  1  level; high requests free-running ticks.
REQ-007 SHALL have port step  input  1  asynchronous button, active-high; a rising edge requests one tick.
REQ-008 SHALL have port x_raw  input  1  asynchronous datapath input x.
REQ-009 SHALL have port y_raw  input  1  asynchronous datapath input y.
REQ-010 SHALL have port tick  output  1  one-cycle clock-enable pulse for the downstream state register.
REQ-011 SHALL have port x_q  output  1  x value presented with tick, stable between ticks.
REQ-012 SHALL have port y_q  output  1  y value presented with tick, stable between ticks.
REQ-013 SHALL have port mode  output  2  current state: 00 IDLE, 01 RUN, 10 STEP.
REQ-014 SHALL have port step_cnt  output  CNT_W  count of ticks issued.

Function
REQ-015 SHALL pass step, x_raw and y_raw through a two-flop synchronizer (3 regs total per input counted with filter stage below).
REQ-016 SHALL detect a step request as filtered step = 1 while the edge register = 0.
REQ-017 In IDLE: run=1 -> RUN next cycle (a step edge in the same cycle is discarded); else a step edge -> STEP; else stay.
REQ-018 STEP SHALL last exactly one cycle, then go to IDLE, or to RUN if run=1.
REQ-019 In RUN: run=0 -> IDLE next cycle; step edges are discarded.
REQ-020 The divider SHALL be cleared to 0 on every entry into RUN and SHALL count only in RUN, wrapping at 2^TICK_DIV-1.
REQ-021 tick SHALL be high in the cycle after the divider reaches 2^TICK_DIV-1 in RUN, giving a first tick 2^TICK_DIV cycles after RUN entry and an exact period of 2^TICK_DIV thereafter.
REQ-022 If run falls in the cycle the divider reaches terminal count, no tick SHALL be issued.
REQ-023 tick SHALL be high during the single cycle mode=STEP.
REQ-024 x_q/y_q SHALL load the filtered x/y on the same edge that raises tick, and SHALL hold otherwise.
REQ-025 step_cnt SHALL increment by 1 on each tick and wrap from 2^CNT_W-1 to 0.
REQ-026 tick SHALL never be high in two consecutive cycles when TICK_DIV >= 1.

Reset
REQ-027 On reset=1 at a clock edge: mode=IDLE, tick=0, x_q=0, y_q=0, step_cnt=0, divider=0, synchronizer and filter regs=0.
REQ-028 The step edge register SHALL reset to 1, so a button held through reset does not produce a step.
REQ-029 Reset asserted in RUN or STEP SHALL abort immediately; no tick in the reset cycle or the cycle after.

Configuration
REQ-030 Macro STEP_SCHED_DEBOUNCE_EN defined: each synchronized step/x/y SHALL change its filtered value only after differing from it for 2^DB_W consecutive cycles; a shorter glitch SHALL be ignored and SHALL restart the count.
REQ-031 Macro STEP_SCHED_DEBOUNCE_EN undefined: filtered value SHALL equal the synchronizer output; DB_W SHALL be unused; latency from raw input to filtered value SHALL be 2 cycles.

Verification (TICK_DIV=4, DB_W=2, CNT_W=4)
REQ-032 reset, run=1 held 40 cycles -> ticks exactly 16 and 32 cycles after RUN entry, step_cnt=2.
REQ-033 IDLE, x_raw=1,y_raw=0, one clean step press -> single one-cycle tick with x_q=1,y_q=0, mode 10 for one cycle then 00, step_cnt=1.
REQ-034 With debounce: step pulse of 3 cycles -> no tick; pulse of 8 cycles -> exactly one tick.
REQ-035 run=1 for 17 ticks -> step_cnt sequences 0..15 then wraps to 0 then 1.
REQ-036 step held high through reset release -> no tick; reset asserted mid-RUN at divider=10 -> mode=00, tick=0, step_cnt=0 next cycle.
